mul_sequencer: RTL and testbench



---
 rtl/mul_pkg.sv | 19 +
 rtl/settle_counter.sv | 28 ++
 rtl/mul_sequencer.sv | 107 ++++++++++
 tb/tb_mul_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the multiplier sequencing stage.
package mul_pkg;

    localparam int unsigned DATA_W            = 32;
    localparam int unsigned PROD_W            = 64;
    localparam int unsigned CNT_W             = 4;
    localparam int unsigned SETTLE_CYCLES_DEF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // High word is not a pure sign extension of the low word.
    function automatic logic prod_overflow(input logic [PROD_W-1:0] p);
        return p[PROD_W-1:DATA_W] != {DATA_W{p[DATA_W-1]}};
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Down-counter that times the multiplier settle window.
module settle_counter
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    // Load on accept, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/mul_sequencer.sv
// Start/settle/capture control around the external combinational multiplier.
module mul_sequencer
    import mul_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
)(
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_start,
    input  logic              in_abort,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic [DATA_W-1:0] out_mul_x,
    output logic [DATA_W-1:0] out_mul_y,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_busy,
    output logic              out_done,
    output logic [DATA_W-1:0] out_hi,
    output logic [DATA_W-1:0] out_lo,
    output logic              out_overflow
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mul_x_d, mul_y_d, hi_d, lo_d;
    logic              busy_d, done_d, ovf_d;
    logic              cnt_load, cnt_dec, cnt_zero;

    settle_counter u_settle_counter (
        .clk        (in_clk),
        .rst_n      (in_rst_n),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (CNT_LOAD),
        .zero_c     (cnt_zero)
    );

    // State and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q      <= IDLE;
            out_mul_x    <= '0;
            out_mul_y    <= '0;
            out_hi       <= '0;
            out_lo       <= '0;
            out_overflow <= 1'b0;
            out_done     <= 1'b0;
            out_busy     <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_mul_x    <= mul_x_d;
            out_mul_y    <= mul_y_d;
            out_hi       <= hi_d;
            out_lo       <= lo_d;
            out_overflow <= ovf_d;
            out_done     <= done_d;
            out_busy     <= busy_d;
        end
    end

    // Next state and next output values; abort wins over both start and capture.
    always_comb begin
        state_d  = state_q;
        mul_x_d  = out_mul_x;
        mul_y_d  = out_mul_y;
        hi_d     = out_hi;
        lo_d     = out_lo;
        ovf_d    = out_overflow;
        busy_d   = out_busy;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_start && !in_abort) begin
                    mul_x_d  = in_x;
                    mul_y_d  = in_y;
                    cnt_load = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (in_abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    hi_d    = in_product[PROD_W-1:DATA_W];
                    lo_d    = in_product[DATA_W-1:0];
                    ovf_d   = prod_overflow(in_product);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer with a behavioural product model.
module tb_mul_sequencer;

    localparam int SC = 2;

    logic        in_clk, in_rst_n, in_start, in_abort;
    logic [31:0] in_x, in_y, out_mul_x, out_mul_y, out_hi, out_lo;
    logic [63:0] in_product;
    logic        out_busy, out_done, out_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [31:0] prev_hi = '0, prev_lo = '0;
    logic        prev_ovf = 1'b0;
    int          last_done_cyc = 0;

    mul_sequencer #(.SETTLE_CYCLES(SC)) dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .in_start     (in_start),
        .in_abort     (in_abort),
        .in_x         (in_x),
        .in_y         (in_y),
        .out_mul_x    (out_mul_x),
        .out_mul_y    (out_mul_y),
        .in_product   (in_product),
        .out_busy     (out_busy),
        .out_done     (out_done),
        .out_hi       (out_hi),
        .out_lo       (out_lo),
        .out_overflow (out_overflow)
    );

    // Stand-in for the external combinational multiplier.
    logic signed [63:0] ext_x, ext_y;
    assign ext_x = {{32{out_mul_x[31]}}, out_mul_x};
    assign ext_y = {{32{out_mul_y[31]}}, out_mul_y};
    assign in_product = ext_x * ext_y;

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    always @(posedge in_clk) begin
        cyc <= cyc + 1;
        if (out_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One operation: start in the current cycle, wait for done, check result.
    task automatic do_op(input logic [31:0] x, input logic [31:0] y);
        longint p;
        logic   exp_ovf;
        int     lat;
        p       = longint'($signed(x)) * longint'($signed(y));
        exp_ovf = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        in_x = x; in_y = y; in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        check("busy_after_start", 64'(out_busy), 64'(1));
        check("opx", 64'(out_mul_x), 64'(x));
        check("opy", 64'(out_mul_y), 64'(y));
        lat = 1;
        while (out_done !== 1'b1 && lat < 20) begin
            @(negedge in_clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(SC + 1));
        check("hi", 64'(out_hi), 64'(p[63:32]));
        check("lo", 64'(out_lo), 64'(p[31:0]));
        check("ovf", 64'(out_overflow), 64'(exp_ovf));
        check("busy_in_done", 64'(out_busy), 64'(0));
        prev_hi = p[63:32]; prev_lo = p[31:0]; prev_ovf = exp_ovf;
        last_done_cyc = cyc;
    endtask

    initial begin
        int d0;
        int c0;
        logic [31:0] rx, ry;
        in_rst_n = 1'b0; in_start = 1'b0; in_abort = 1'b0; in_x = '0; in_y = '0;
        repeat (2) @(negedge in_clk);
        check("rst_hi", 64'(out_hi), 64'(0));
        check("rst_lo", 64'(out_lo), 64'(0));
        check("rst_flags", 64'({out_busy, out_done, out_overflow}), 64'(0));
        check("rst_ops", {out_mul_x, out_mul_y}, 64'(0));
        in_rst_n = 1'b1;
        @(negedge in_clk);

        // Directed cases.
        do_op(32'd10, 32'd10);
        @(negedge in_clk);
        do_op(32'hFFFF_FFF3, 32'd11);
        check("neg_lo", 64'(out_lo), 64'(32'hFFFF_FF71));
        @(negedge in_clk);
        do_op(32'h0001_0000, 32'h0001_0000);
        check("big_ovf", 64'(out_overflow), 64'(1));
        @(negedge in_clk);
        do_op(32'h8000_0000, 32'h8000_0000);
        @(negedge in_clk);
        do_op(32'h8000_0000, 32'd1);
        @(negedge in_clk);
        do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF);
        @(negedge in_clk);

        // Start pulsed during SETTLE is ignored.
        d0 = done_cnt;
        in_x = 32'd96; in_y = 32'd86; in_start = 1'b1;
        @(negedge in_clk);
        in_x = 32'd3; in_y = 32'd3;
        @(negedge in_clk);
        in_start = 1'b0;
        check("hold_x", 64'(out_mul_x), 64'(96));
        @(negedge in_clk);
        check("ign_done", 64'(out_done), 64'(1));
        check("ign_lo", 64'(out_lo), 64'(8256));
        check("ign_y", 64'(out_mul_y), 64'(86));
        prev_hi = out_hi; prev_lo = 32'd8256; prev_ovf = 1'b0;
        repeat (4) @(negedge in_clk);
        check("ign_single_done", 64'(done_cnt - d0), 64'(1));
        check("ign_idle", 64'(out_busy), 64'(0));

        // Abort on the final settle cycle suppresses capture.
        d0 = done_cnt;
        in_x = 32'd1234; in_y = 32'd5678; in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        @(negedge in_clk);
        in_abort = 1'b1;
        @(negedge in_clk);
        in_abort = 1'b0;
        check("abort_busy", 64'(out_busy), 64'(0));
        repeat (4) @(negedge in_clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));
        check("abort_keep", {out_hi, out_lo}, {prev_hi, prev_lo});
        check("abort_keep_ovf", 64'(out_overflow), 64'(prev_ovf));

        // Abort in IDLE overrides start.
        d0 = done_cnt;
        in_x = 32'd5; in_y = 32'd7; in_start = 1'b1; in_abort = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0; in_abort = 1'b0;
        check("idle_abort_busy", 64'(out_busy), 64'(0));
        check("idle_abort_ops", {out_mul_x, out_mul_y}, {32'd1234, 32'd5678});
        repeat (4) @(negedge in_clk);
        check("idle_abort_no_done", 64'(done_cnt - d0), 64'(0));

        // Reset asserted mid-settle clears everything at once.
        in_x = 32'd77; in_y = 32'd3; in_start = 1'b1;
        @(negedge in_clk);
        in_start = 1'b0;
        in_rst_n = 1'b0;
        #1;
        check("mid_rst_res", {out_hi, out_lo}, 64'(0));
        check("mid_rst_ops", {out_mul_x, out_mul_y}, 64'(0));
        check("mid_rst_flags", 64'({out_busy, out_done, out_overflow}), 64'(0));
        @(negedge in_clk);
        in_rst_n = 1'b1;
        @(negedge in_clk);
        do_op(32'd6, 32'd7);

        // Back-to-back random operations, start issued in each done cycle.
        c0 = last_done_cyc;
        for (int i = 0; i < 24; i++) begin
            rx = $urandom;
            ry = $urandom;
            if (i % 3 == 1) begin
                rx = 32'($signed(16'($urandom)));
                ry = 32'($signed(12'($urandom)));
            end
            do_op(rx, ry);
            check("spacing", 64'(last_done_cyc - c0), 64'(SC + 1));
            c0 = last_done_cyc;
        end
        @(negedge in_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
